// File: rtl/grf_hazard_scoreboard_pkg.sv
// Shared encodings and stage-record layout for the GRF hazard scoreboard.
// Forward selects, Tuse/Tnew codes and record helpers live here.
package grf_hazard_scoreboard_pkg;

  localparam int REG_W   = 5;
  localparam int TNEW_W  = 2;
  localparam int FWD_W   = 2;
  localparam int MDCNT_W = 4;

  localparam logic [FWD_W-1:0] FWD_GRF = 2'd0;
  localparam logic [FWD_W-1:0] FWD_E   = 2'd1;
  localparam logic [FWD_W-1:0] FWD_M   = 2'd2;
  localparam logic [FWD_W-1:0] FWD_W_S = 2'd3;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [TNEW_W-1:0] TNEW_NOW  = 2'd0;
  localparam logic [TNEW_W-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TNEW_W-1:0] TNEW_LOAD = 2'd2;

  typedef logic [REG_W-1:0]  reg_t;
  typedef logic [TNEW_W-1:0] tnew_t;
  typedef logic [FWD_W-1:0]  fwd_t;

  typedef struct packed {
    reg_t  rs;
    reg_t  rt;
    reg_t  a3;
    logic  we;
    tnew_t tnew;
    logic  md_start;
    logic  is_div;
  } stage_rec_t;

  localparam stage_rec_t REC_BUBBLE = '0;

  function automatic logic writes(stage_rec_t s, reg_t r);
    return s.we && (s.a3 == r) && (r != '0);
  endfunction

  function automatic tnew_t tnew_dec(tnew_t t);
    return (t == '0) ? t : t - 1'b1;
  endfunction

  // Nearest writer wins; a not-yet-ready producer yields GRF (stall covers it).
  function automatic fwd_t fwd_sel(stage_rec_t e, stage_rec_t m,
                                   stage_rec_t w, reg_t r);
    fwd_t f;
    f = FWD_GRF;
    if (writes(e, r))      f = (e.tnew == '0) ? FWD_E   : FWD_GRF;
    else if (writes(m, r)) f = (m.tnew == '0) ? FWD_M   : FWD_GRF;
    else if (writes(w, r)) f = (w.tnew == '0) ? FWD_W_S : FWD_GRF;
    return f;
  endfunction

endpackage

// File: rtl/grf_hazard_scoreboard_if.sv
// Decode-side request and hazard-control response bundle.
// master drives the D-stage fields, slave returns stall and forwards.
interface grf_hazard_scoreboard_if;
  import grf_hazard_scoreboard_pkg::*;

  reg_t  D_RS;
  reg_t  D_RT;
  logic [1:0] D_TuseRS;
  logic [1:0] D_TuseRT;
  reg_t  D_A3;
  logic  D_RegWrite;
  tnew_t D_Tnew;
  logic  D_MDStart;
  logic  D_IsDiv;
  logic  D_MDUse;

  logic  Stall;
  fwd_t  D_FwdRS;
  fwd_t  D_FwdRT;
  fwd_t  E_FwdRS;
  fwd_t  E_FwdRT;
  fwd_t  M_FwdRT;
  logic  MD_Busy;

  modport master (
    output D_RS, D_RT, D_TuseRS, D_TuseRT, D_A3,
           D_RegWrite, D_Tnew, D_MDStart, D_IsDiv, D_MDUse,
    input  Stall, D_FwdRS, D_FwdRT, E_FwdRS, E_FwdRT,
           M_FwdRT, MD_Busy
  );

  modport slave (
    input  D_RS, D_RT, D_TuseRS, D_TuseRT, D_A3,
           D_RegWrite, D_Tnew, D_MDStart, D_IsDiv, D_MDUse,
    output Stall, D_FwdRS, D_FwdRT, E_FwdRS, E_FwdRT,
           M_FwdRT, MD_Busy
  );

endinterface

// File: rtl/grf_hazard_scoreboard_md_busy_counter.sv
// Mult/div busy countdown: loads when a start record leaves E,
// otherwise counts down to zero.
module md_busy_counter
  import grf_hazard_scoreboard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o
);

  localparam logic [MDCNT_W-1:0] MULT_LD = MDCNT_W'(MULT_CYCLES);
  localparam logic [MDCNT_W-1:0] DIV_LD  = MDCNT_W'(DIV_CYCLES);

  logic [MDCNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i)
      cnt_d = is_div_i ? DIV_LD : MULT_LD;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/grf_hazard_scoreboard.sv
// GRF hazard controller: E/M/W writer records, stall and forward selects,
// plus HI/LO interlock through the mult/div busy counter.
module grf_hazard_scoreboard
  import grf_hazard_scoreboard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic Clk,
  input  logic Reset,
  grf_hazard_scoreboard_if.slave hz
);

  stage_rec_t e_q, m_q, w_q;
  stage_rec_t e_d, m_d, w_d;
  logic stall_rs, stall_rt, stall_md, stall;
  logic md_busy;
  logic w_unused;

  always_comb begin
    stall_rs = (writes(e_q, hz.D_RS) && (hz.D_TuseRS < e_q.tnew))
            || (writes(m_q, hz.D_RS) && (hz.D_TuseRS < m_q.tnew));
    stall_rt = (writes(e_q, hz.D_RT) && (hz.D_TuseRT < e_q.tnew))
            || (writes(m_q, hz.D_RT) && (hz.D_TuseRT < m_q.tnew));
    stall_md = hz.D_MDUse && (e_q.md_start || md_busy);
    stall    = stall_rs || stall_rt || stall_md;
  end

  always_comb begin
    e_d          = REC_BUBBLE;
    if (!stall) begin
      e_d.rs       = hz.D_RS;
      e_d.rt       = hz.D_RT;
      e_d.a3       = hz.D_A3;
      e_d.we       = hz.D_RegWrite;
      e_d.tnew     = hz.D_Tnew;
      e_d.md_start = hz.D_MDStart;
      e_d.is_div   = hz.D_IsDiv;
    end
    m_d      = e_q;
    m_d.tnew = tnew_dec(e_q.tnew);
    w_d      = m_q;
    w_d.tnew = tnew_dec(m_q.tnew);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      e_q <= REC_BUBBLE;
      m_q <= REC_BUBBLE;
      w_q <= REC_BUBBLE;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .start_i  (e_q.md_start),
    .is_div_i (e_q.is_div),
    .busy_o   (md_busy)
  );

  // W only supplies a3/we/tnew; its source fields are carried but unread.
  assign w_unused = ^{w_q.rs, w_q.rt, w_q.md_start, w_q.is_div};

  assign hz.Stall   = stall;
  assign hz.MD_Busy = md_busy;
  assign hz.D_FwdRS = fwd_sel(e_q, m_q, w_q, hz.D_RS);
  assign hz.D_FwdRT = fwd_sel(e_q, m_q, w_q, hz.D_RT);
  assign hz.E_FwdRS = fwd_sel(REC_BUBBLE, m_q, w_q, e_q.rs);
  assign hz.E_FwdRT = fwd_sel(REC_BUBBLE, m_q, w_q, e_q.rt);
  assign hz.M_FwdRT = fwd_sel(REC_BUBBLE, REC_BUBBLE, w_q, m_q.rt);

endmodule

// File: tb/tb_grf_hazard_scoreboard.sv
// Bench for grf_hazard_scoreboard: instruction-stream vector table
// plus mult/div interlock and reset-abort sequences.
module tb_grf_hazard_scoreboard;

  logic Clk;
  logic Reset;

  grf_hazard_scoreboard_if hz();

  grf_hazard_scoreboard #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .hz    (hz)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [1:0]  trs;
    logic [1:0]  trt;
    logic [4:0]  a3;
    logic        we;
    logic [1:0]  tn;
    logic        md;
    logic        dv;
    logic        mu;
    logic [11:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  vec_t tbl[22];

  function automatic logic [11:0] X(logic st, logic [1:0] dfs,
      logic [1:0] dft, logic [1:0] efs, logic [1:0] eft,
      logic [1:0] mft, logic b);
    return {st, dfs, dft, efs, eft, mft, b};
  endfunction

  function automatic vec_t I(logic [4:0] rs, logic [4:0] rt,
      logic [1:0] trs, logic [1:0] trt, logic [4:0] a3, logic we,
      logic [1:0] tn, logic [11:0] e);
    vec_t v;
    v.rs = rs; v.rt = rt; v.trs = trs; v.trt = trt;
    v.a3 = a3; v.we = we; v.tn = tn;
    v.md = 1'b0; v.dv = 1'b0; v.mu = 1'b0;
    v.exp = e;
    return v;
  endfunction

  function automatic vec_t MD(logic start, logic dv);
    vec_t v;
    v = I(start ? 5'd8 : 5'd0, start ? 5'd9 : 5'd0,
          start ? 2'd1 : 2'd3, start ? 2'd1 : 2'd3,
          start ? 5'd0 : 5'd10, !start, start ? 2'd0 : 2'd1, '0);
    v.md = start;
    v.dv = dv;
    v.mu = 1'b1;
    return v;
  endfunction

  function automatic logic [11:0] outs();
    return {hz.Stall, hz.D_FwdRS, hz.D_FwdRT, hz.E_FwdRS,
            hz.E_FwdRT, hz.M_FwdRT, hz.MD_Busy};
  endfunction

  task automatic drive(input vec_t v);
    hz.D_RS       = v.rs;
    hz.D_RT       = v.rt;
    hz.D_TuseRS   = v.trs;
    hz.D_TuseRT   = v.trt;
    hz.D_A3       = v.a3;
    hz.D_RegWrite = v.we;
    hz.D_Tnew     = v.tn;
    hz.D_MDStart  = v.md;
    hz.D_IsDiv    = v.dv;
    hz.D_MDUse    = v.mu;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic run_md(input logic dv, input int exp_cyc,
                        input string nm);
    int n;
    drive(MD(1'b1, dv));
    #1 chk({nm, "_start"}, 32'(outs()), 32'(X(0,0,0,0,0,0,0)));
    @(negedge Clk);
    drive(MD(1'b0, 1'b0));
    #1;
    n = 0;
    while (hz.Stall && n < 40) begin
      chk({nm, "_busy"}, 32'(hz.MD_Busy), 32'(n != 0));
      n++;
      @(negedge Clk);
      #1;
    end
    chk({nm, "_stall_cycles"}, 32'(n), 32'(exp_cyc));
    chk({nm, "_busy_clear"}, 32'(hz.MD_Busy), 32'd0);
    @(negedge Clk);
    drive(I(0,0,3,3,0,0,0,'0));
    #1 chk({nm, "_after"}, 32'(outs()), 32'(X(0,0,0,0,0,0,0)));
    @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t nop;
    nop = I(0,0,3,3,0,0,0, X(0,0,0,0,0,0,0));
    tbl[0]  = I(2,3,1,1,1,1,1, X(0,0,0,0,0,0,0));
    tbl[1]  = I(1,0,0,0,0,0,0, X(1,0,0,0,0,0,0));
    tbl[2]  = I(1,0,0,0,0,0,0, X(0,2,0,0,0,0,0));
    tbl[3]  = I(0,0,3,3,0,0,0, X(0,0,0,3,0,0,0));
    tbl[4]  = nop;
    tbl[5]  = I(0,0,1,3,4,1,2, X(0,0,0,0,0,0,0));
    tbl[6]  = I(4,4,1,1,5,1,1, X(1,0,0,0,0,0,0));
    tbl[7]  = I(4,4,1,1,5,1,1, X(0,0,0,0,0,0,0));
    tbl[8]  = I(0,5,1,2,0,0,0, X(0,0,0,3,3,0,0));
    tbl[9]  = I(0,0,3,3,0,0,0, X(0,0,0,0,2,0,0));
    tbl[10] = I(0,0,3,3,0,0,0, X(0,0,0,0,0,3,0));
    tbl[11] = I(0,0,1,3,6,1,1, X(0,0,0,0,0,0,0));
    tbl[12] = nop;
    tbl[13] = nop;
    tbl[14] = I(6,0,0,0,0,0,0, X(0,3,0,0,0,0,0));
    tbl[15] = I(0,0,3,3,7,1,0, X(0,0,0,0,0,0,0));
    tbl[16] = I(7,7,0,0,0,0,0, X(0,1,1,0,0,0,0));
    tbl[17] = I(0,0,3,3,0,0,0, X(0,0,0,2,2,0,0));
    tbl[18] = I(1,1,1,1,0,1,1, X(0,0,0,0,0,3,0));
    tbl[19] = I(0,0,0,0,0,0,0, X(0,0,0,0,0,0,0));
    tbl[20] = nop;
    tbl[21] = nop;

    Reset = 1'b1;
    drive(nop);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i]);
      exp_q.push_back(tbl[i].exp);
      #1;
      begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chk($sformatf("vec%0d", i), 32'(outs()), 32'(e));
      end
      @(negedge Clk);
    end

    run_md(1'b1, 11, "div");
    run_md(1'b0, 6, "mult");

    drive(MD(1'b1, 1'b1));
    #1;
    @(negedge Clk);
    drive(MD(1'b0, 1'b0));
    repeat (4) @(negedge Clk);
    #1 chk("rst_pre_stall", 32'(hz.Stall), 32'd1);
    chk("rst_pre_busy", 32'(hz.MD_Busy), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    #1 chk("rst_clear", 32'(outs()), 32'(X(0,0,0,0,0,0,0)));
    @(negedge Clk);
    drive(nop);
    #1 chk("rst_mfhi_in_e", 32'(outs()), 32'(X(0,0,0,0,0,0,0)));
    @(negedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grf_hazard_scoreboard.md
Name: grf_hazard_scoreboard

Overview:
- Pipeline hazard controller for the GRF in the 5-stage MIPS core.
- Tracks destination register and Tnew of every in-flight writer in stages E, M and W.
- Compares them with operand reads in D, E and M, and produces the F/D stall and bubble request plus forwarding selects for every GRF read point.
- Also sequences the multi-cycle mult/div unit with a busy counter, so that HI/LO users stall.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu leaves E.
- DIV_CYCLES, 10, busy cycles after a div/divu leaves E.

Ports:
- Clk  in  1  system clock, posedge.
- Reset  in  1  synchronous, active-high.
- D_RS  in  5  rs field of instruction in D.
- D_RT  in  5  rt field of instruction in D.
- D_TuseRS  in  2  cycles until rs is needed (0..2; 3 = unused).
- D_TuseRT  in  2  as above, for rt.
- D_A3  in  5  destination register of instruction in D.
- D_RegWrite  in  1  instruction in D writes the GRF.
- D_Tnew  in  2  cycles after entering E until result is valid (ALU 1, load 2, jal/lui 0).
- D_MDStart  in  1  instruction in D is mult/multu/div/divu.
- D_IsDiv  in  1  qualifies D_MDStart.
- D_MDUse  in  1  instruction in D reads or writes HI/LO or starts mult/div.
- Stall  out  1  freeze PC and F/D register; load bubble into D/E.
- D_FwdRS  out  2  D read select for rs: 0 GRF, 1 E, 2 M, 3 W.
- D_FwdRT  out  2  as above, for rt.
- E_FwdRS  out  2  E read select for rs: 0 pipeline value, 2 M, 3 W.
- E_FwdRT  out  2  as above, for rt.
- M_FwdRT  out  2  M store-data select: 0 pipeline value, 3 W.
- MD_Busy  out  1  mult/div counter non-zero.

Behaviour:
- Internal stage records E, M, W; each holds {RS, RT, A3, WE, Tnew, MDStart, IsDiv}.
- Record advance at every posedge, when not stalled:
  - D fields load into E.
  - E shifts to M.
  - M shifts to W.
  - Tnew decrements, saturating at 0.
- Record advance when Stall=1:
  - E loads a bubble (all fields 0).
  - M and W still shift.
- Reset: all records, counter and outputs cleared; Stall=0, all Fwd=0, MD_Busy=0 in the cycle after Reset is sampled.
  - Reset mid-stall or mid-divide aborts immediately; no pending state survives.
- Writer definition: a stage is a writer for register r iff WE=1, A3=r and r!=0. Register 0 never matches: no forward, no stall.
- Data stall for rs: rs is a writer target in E with D_TuseRS < E.Tnew, or in M with D_TuseRS < M.Tnew. rt is checked the same way.
- Stall = rs data stall OR rt data stall OR MD stall. Stall is purely combinational from the current records and the D inputs; zero-cycle latency.
- D forwarding: the nearest writer wins (E > M > W), and only if that stage's Tnew=0. If the nearest writer has Tnew>0, select 0; the stall covers it.
  - W to D forwarding is mandatory: the GRF has no internal write-through.
- E forwarding: E.RS/E.RT compared against M then W, under the same Tnew=0 rule. M_FwdRT compares M.RT against W.
- MD counter (4 bits):
  - Loads MULT_CYCLES or DIV_CYCLES on the edge where an MDStart record leaves E.
  - Otherwise decrements to 0.
  - MD_Busy = count!=0.
- MD stall = D_MDUse AND (E.MDStart OR MD_Busy).
- Simultaneous events:
  - Data stall and MD stall together produce a single Stall.
  - A new MDStart cannot enter E while busy, because it is stalled.

Decomposition:
- Shared package (constants file):
  - FWD_GRF=0, FWD_E=1, FWD_M=2, FWD_W=3.
  - TUSE_NONE=3.
  - Tnew encodings.
  - Stage-record bit-field widths.
- One natural sub-module: md_busy_counter (load/decrement/busy), instantiated once.
- Stall and forward comparators stay in the top level.

Test Plan:
- addu $1,$2,$3 then beq $1,$0 (TuseRS=0, Tnew=1): Stall=1 for 1 cycle; next cycle D_FwdRS=2 (M).
- lw $4,0($0) then addu $5,$4,$4 (Tuse=1, Tnew=2): Stall=1 for 1 cycle, then E_FwdRS=E_FwdRT=2 when the load is in W? No: the load is in W by then, so E_FwdRS=E_FwdRT=3.
- ori $6,$0,5 three slots before beq $6: D_FwdRS=3 (W), Stall=0.
- addu $0,$1,$1 then beq $0,$0: Stall=0, D_FwdRS=D_FwdRT=0.
- div then mfhi immediately: Stall=1 while in E plus 10 busy cycles (11 total); MD_Busy falls, then mfhi proceeds. Repeat with mult: 6 cycles.
- Reset asserted during the div busy window: next cycle MD_Busy=0, Stall=0, all Fwd=0; a following mfhi is not stalled.
